// File: rtl/xadc_scan_ctrl.sv
// Scan sequencer for the XADC single-channel reader: walks channels, averages 2^k samples each, streams results.
// Optional macro XADC_SCAN_MINMAX_EN adds per-channel res_min/res_max outputs.
module xadc_scan_ctrl #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int MAX_LOG2    = 7
) (
    input  logic        clk125,
    input  logic        rst_n,
    input  logic        scan_start,
    input  logic [4:0]  ch_base,
    input  logic [3:0]  n_ch,
    input  logic [2:0]  avg_log2,
    input  logic [15:0] sample_gap,
    output logic        xadc_start,
    output logic [4:0]  xadc_ch_sel,
    input  logic        xadc_done,
    input  logic [11:0] xadc_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [4:0]  res_ch,
    output logic [11:0] res_data,
    output logic        res_err,
    output logic        scan_busy,
    output logic        scan_done,
    output logic        err_timeout
`ifdef XADC_SCAN_MINMAX_EN
    ,
    output logic [11:0] res_min,
    output logic [11:0] res_max
`endif
);

    localparam int ACC_W = 12 + MAX_LOG2;
    localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;
    localparam int SMP_W = MAX_LOG2 + 1;
    localparam logic [2:0] K_MAX = (MAX_LOG2 > 7) ? 3'd7 : 3'(MAX_LOG2);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_GAP       = 3'd3,
        S_EMIT      = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [4:0]         r_base;
    logic [3:0]         r_nch;
    logic [2:0]         r_k;
    logic [15:0]        r_gap;
    logic [15:0]        r_gap_cnt;
    logic [3:0]         r_idx;
    logic [ACC_W-1:0]   r_acc;
    logic [SMP_W-1:0]   r_smp;
    logic [WD_W-1:0]    r_wdog;
    logic               r_xadc_start;
    logic [4:0]         r_ch_sel;
    logic               r_res_valid;
    logic [4:0]         r_res_ch;
    logic [11:0]        r_res_data;
    logic               r_res_err;
    logic               r_scan_busy;
    logic               r_scan_done;
    logic               r_err_to;

    logic [2:0]         w_k_clamp;
    logic [ACC_W-1:0]   w_sum;
    logic [11:0]        w_avg;
    logic [SMP_W-1:0]   w_smp_inc;
    logic               w_last;
    logic               w_wd_expire;

    assign w_k_clamp   = (avg_log2 > K_MAX) ? K_MAX : avg_log2;
    assign w_sum       = r_acc + ACC_W'(xadc_result);
    assign w_avg       = 12'(w_sum >> r_k);
    assign w_smp_inc   = r_smp + SMP_W'(1);
    assign w_last      = (w_smp_inc == (SMP_W'(1) << r_k));
    assign w_wd_expire = (r_wdog == WD_W'(TIMEOUT_CYC - 1));

    // Next-state decode; done beats a coincident watchdog expiry
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (scan_start) begin
                    w_next = (n_ch == 4'd0) ? S_FINISH : S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (xadc_done) begin
                    if (w_last) begin
                        w_next = S_EMIT;
                    end else if (r_gap == 16'd0) begin
                        w_next = S_ISSUE;
                    end else begin
                        w_next = S_GAP;
                    end
                end else if (w_wd_expire) begin
                    w_next = S_EMIT;
                end else begin
                    w_next = S_WAIT_DONE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == r_gap - 16'd1) begin
                    w_next = S_ISSUE;
                end else begin
                    w_next = S_GAP;
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    w_next = (r_idx + 4'd1 == r_nch) ? S_FINISH : S_ISSUE;
                end else begin
                    w_next = S_EMIT;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_base       <= 5'd0;
            r_nch        <= 4'd0;
            r_k          <= 3'd0;
            r_gap        <= 16'd0;
            r_gap_cnt    <= 16'd0;
            r_idx        <= 4'd0;
            r_acc        <= '0;
            r_smp        <= '0;
            r_wdog       <= '0;
            r_xadc_start <= 1'b0;
            r_ch_sel     <= 5'd0;
            r_res_valid  <= 1'b0;
            r_res_ch     <= 5'd0;
            r_res_data   <= 12'd0;
            r_res_err    <= 1'b0;
            r_scan_busy  <= 1'b0;
            r_scan_done  <= 1'b0;
            r_err_to     <= 1'b0;
        end else begin
            r_state      <= w_next;
            // Start pulse lands one cycle after ISSUE, giving the 2-cycle scan_start latency
            r_xadc_start <= (r_state == S_ISSUE);
            r_res_valid  <= (w_next == S_EMIT);
            r_scan_busy  <= (w_next != S_IDLE);
            r_scan_done  <= (w_next == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (scan_start) begin
                        r_base   <= ch_base;
                        r_nch    <= n_ch;
                        r_k      <= w_k_clamp;
                        r_gap    <= sample_gap;
                        r_err_to <= 1'b0;
                        r_idx    <= 4'd0;
                        r_acc    <= '0;
                        r_smp    <= '0;
                    end
                end
                S_ISSUE: begin
                    r_ch_sel <= r_base + {1'b0, r_idx};
                    r_wdog   <= '0;
                end
                S_WAIT_DONE: begin
                    if (xadc_done) begin
                        r_acc     <= w_sum;
                        r_smp     <= w_smp_inc;
                        r_gap_cnt <= 16'd0;
                        if (w_last) begin
                            r_res_ch   <= r_ch_sel;
                            r_res_data <= w_avg;
                            r_res_err  <= 1'b0;
                        end
                    end else if (w_wd_expire) begin
                        r_err_to   <= 1'b1;
                        r_res_ch   <= r_ch_sel;
                        r_res_data <= 12'hFFF;
                        r_res_err  <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                S_GAP: r_gap_cnt <= r_gap_cnt + 16'd1;
                S_EMIT: begin
                    if (res_ready) begin
                        r_acc     <= '0;
                        r_smp     <= '0;
                        r_res_err <= 1'b0;
                        r_idx     <= r_idx + 4'd1;
                    end
                end
                S_FINISH: r_idx <= 4'd0;
                default:  r_idx <= 4'd0;
            endcase
        end
    end

    assign xadc_start  = r_xadc_start;
    assign xadc_ch_sel = r_ch_sel;
    assign res_valid   = r_res_valid;
    assign res_ch      = r_res_ch;
    assign res_data    = r_res_data;
    assign res_err     = r_res_err;
    assign scan_busy   = r_scan_busy;
    assign scan_done   = r_scan_done;
    assign err_timeout = r_err_to;

`ifdef XADC_SCAN_MINMAX_EN
    logic [11:0] r_min_run;
    logic [11:0] r_max_run;
    logic [11:0] r_res_min;
    logic [11:0] r_res_max;
    logic [11:0] w_min_nx;
    logic [11:0] w_max_nx;

    assign w_min_nx = (xadc_result < r_min_run) ? xadc_result : r_min_run;
    assign w_max_nx = (xadc_result > r_max_run) ? xadc_result : r_max_run;

    // Running per-channel extremes, snapshotted into the result on entry to EMIT
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            r_min_run <= 12'hFFF;
            r_max_run <= 12'h000;
            r_res_min <= 12'h000;
            r_res_max <= 12'h000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (scan_start) begin
                        r_min_run <= 12'hFFF;
                        r_max_run <= 12'h000;
                    end
                end
                S_WAIT_DONE: begin
                    if (xadc_done) begin
                        r_min_run <= w_min_nx;
                        r_max_run <= w_max_nx;
                        if (w_last) begin
                            r_res_min <= w_min_nx;
                            r_res_max <= w_max_nx;
                        end
                    end else if (w_wd_expire) begin
                        r_res_min <= r_min_run;
                        r_res_max <= r_max_run;
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        r_min_run <= 12'hFFF;
                        r_max_run <= 12'h000;
                    end
                end
                default: r_min_run <= r_min_run;
            endcase
        end
    end

    assign res_min = r_res_min;
    assign res_max = r_res_max;
`endif

endmodule

// File: tb/tb_xadc_scan_ctrl.sv
// Directed, table-driven bench for xadc_scan_ctrl with a behavioural XADC reader and a stalling consumer.
module tb_xadc_scan_ctrl;

    localparam int TO     = 4096;
    localparam int BUDGET = 20000;

    logic        clk125 = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_start = 1'b0;
    logic [4:0]  ch_base = 5'd0;
    logic [3:0]  n_ch = 4'd0;
    logic [2:0]  avg_log2 = 3'd0;
    logic [15:0] sample_gap = 16'd0;
    logic        xadc_start;
    logic [4:0]  xadc_ch_sel;
    logic        xadc_done = 1'b0;
    logic [11:0] xadc_result = 12'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [4:0]  res_ch;
    logic [11:0] res_data;
    logic        res_err;
    logic        scan_busy;
    logic        scan_done;
    logic        err_timeout;

    xadc_scan_ctrl #(.TIMEOUT_CYC(TO), .MAX_LOG2(7)) dut (
        .clk125(clk125), .rst_n(rst_n), .scan_start(scan_start), .ch_base(ch_base),
        .n_ch(n_ch), .avg_log2(avg_log2), .sample_gap(sample_gap),
        .xadc_start(xadc_start), .xadc_ch_sel(xadc_ch_sel), .xadc_done(xadc_done),
        .xadc_result(xadc_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_data(res_data), .res_err(res_err), .scan_busy(scan_busy),
        .scan_done(scan_done), .err_timeout(err_timeout)
    );

    always #4 clk125 = ~clk125;

    typedef struct {
        logic [4:0]       base;
        logic [3:0]       nch;
        logic [2:0]       avg;
        logic [15:0]      gap;
        int               stall;
        int               lat;
        bit               drop_en;
        logic [4:0]       drop;
        bit               mid;
        int               npre;
        logic [3:0][11:0] pre;
        int               exp_starts;
        int               exp_res;
        logic [15:0]      exp_mask;
        logic [11:0]      exp_d0;
        logic             exp_to;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_fail   = 0;

    // Reader model, consumer and start monitor state
    int          lat = 3;
    bit          drop_en = 1'b0;
    logic [4:0]  drop_ch = 5'd0;
    logic [11:0] rq[$];
    bit          outst = 1'b0;
    bit          outst_drop = 1'b0;
    int          rcnt = 0;
    int          n_starts = 0;
    int          start_cyc[$];
    int          cyc = 0;
    logic        prev_start = 1'b0;
    int          n_done_pulses = 0;
    int          stall_cyc = 0;
    bit          stalling = 1'b0;
    int          scnt = 0;
    logic [4:0]  cap_ch;
    logic [11:0] cap_data;
    logic        cap_err;
    logic [4:0]  got_ch[$];
    logic [11:0] got_data[$];
    logic        got_err[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {4'd0, xadc_start, xadc_ch_sel, res_valid, res_ch, res_data, res_err,
                scan_busy, scan_done, err_timeout};
    endfunction

    // Environment: everything sampled and driven on the falling edge
    initial begin
        forever begin
            @(negedge clk125);
            cyc++;
            if (!rst_n) begin
                xadc_done  = 1'b0;
                outst      = 1'b0;
                outst_drop = 1'b0;
                stalling   = 1'b0;
                prev_start = 1'b0;
                res_ready  = (stall_cyc == 0);
            end else begin
                if (xadc_done) begin
                    xadc_done = 1'b0;
                end else if (outst && !outst_drop) begin
                    rcnt++;
                    if (rcnt == lat) begin
                        xadc_done   = 1'b1;
                        xadc_result = (rq.size() > 0) ? rq.pop_front() : 12'h100 + {7'd0, xadc_ch_sel};
                        outst       = 1'b0;
                    end
                end
                if (xadc_start) begin
                    n_starts++;
                    start_cyc.push_back(cyc);
                    chk("start_width", {31'd0, prev_start}, 32'd0);
                    chk("start_outstanding", {31'd0, outst && !outst_drop}, 32'd0);
                    chk("start_in_stall", {31'd0, stalling}, 32'd0);
                    outst      = 1'b1;
                    rcnt       = 0;
                    outst_drop = drop_en && (xadc_ch_sel == drop_ch);
                end
                prev_start = xadc_start;
                if (scan_done) n_done_pulses++;
                if (stall_cyc == 0) begin
                    res_ready = 1'b1;
                    if (res_valid) begin
                        got_ch.push_back(res_ch);
                        got_data.push_back(res_data);
                        got_err.push_back(res_err);
                    end
                end else if (res_ready) begin
                    res_ready = 1'b0;
                    stalling  = 1'b0;
                end else if (res_valid) begin
                    if (!stalling) begin
                        cap_ch   = res_ch;
                        cap_data = res_data;
                        cap_err  = res_err;
                        stalling = 1'b1;
                        scnt     = 0;
                    end else begin
                        chk("stall_hold", {18'd0, res_ch, res_data, res_err}, {18'd0, cap_ch, cap_data, cap_err});
                    end
                    scnt++;
                    if (scnt >= stall_cyc) begin
                        res_ready = 1'b1;
                        got_ch.push_back(cap_ch);
                        got_data.push_back(cap_data);
                        got_err.push_back(cap_err);
                    end
                end
            end
        end
    end

    task automatic run_scan(input vec_t v, input string tag);
        int t;
        int t_first;
        bit mid_sent;
        logic [4:0]  e_ch;
        logic [11:0] e_d;
        logic        e_err;
        @(negedge clk125);
        rq.delete();
        start_cyc.delete();
        got_ch.delete();
        got_data.delete();
        got_err.delete();
        n_starts      = 0;
        n_done_pulses = 0;
        lat           = v.lat;
        drop_en       = v.drop_en;
        drop_ch       = v.drop;
        stall_cyc     = v.stall;
        res_ready     = (v.stall == 0);
        for (int j = 0; j < v.npre; j++) rq.push_back(v.pre[j]);
        ch_base    = v.base;
        n_ch       = v.nch;
        avg_log2   = v.avg;
        sample_gap = v.gap;
        scan_start = 1'b1;
        @(negedge clk125);
        scan_start = 1'b0;
        chk({tag, "_busy_after_start"}, {31'd0, scan_busy || (v.nch == 4'd0)}, 32'd1);
        chk({tag, "_err_cleared"}, {31'd0, err_timeout}, 32'd0);
        t        = 0;
        t_first  = -1;
        mid_sent = 1'b0;
        while (!scan_done && t < BUDGET) begin
            if (xadc_start && t_first < 0) t_first = t;
            if (v.mid && !mid_sent && xadc_start) begin
                scan_start = 1'b1;
                ch_base    = 5'd0;
                n_ch       = 4'd0;
                mid_sent   = 1'b1;
            end
            @(negedge clk125);
            t++;
            scan_start = 1'b0;
        end
        chk({tag, "_done_seen"}, {31'd0, t < BUDGET}, 32'd1);
        if (v.nch == 4'd0) chk({tag, "_done_latency_le1"}, {31'd0, t <= 1}, 32'd1);
        else chk({tag, "_first_start_latency"}, t_first, 32'd1);
        @(negedge clk125);
        chk({tag, "_busy_dropped"}, {31'd0, scan_busy}, 32'd0);
        repeat (2) @(negedge clk125);
        chk({tag, "_done_pulses"}, n_done_pulses, 32'd1);
        chk({tag, "_n_starts"}, n_starts, v.exp_starts);
        chk({tag, "_n_results"}, got_ch.size(), v.exp_res);
        chk({tag, "_err_timeout"}, {31'd0, err_timeout}, {31'd0, v.exp_to});
        for (int i = 0; i < v.exp_res && i < got_ch.size(); i++) begin
            e_ch  = v.base + 5'(i);
            e_err = v.exp_mask[i];
            e_d   = e_err ? 12'hFFF : ((i == 0) ? v.exp_d0 : 12'h100 + {7'd0, e_ch});
            chk({tag, "_res_ch"}, {27'd0, got_ch[i]}, {27'd0, e_ch});
            chk({tag, "_res_data"}, {20'd0, got_data[i]}, {20'd0, e_d});
            chk({tag, "_res_err"}, {31'd0, got_err[i]}, {31'd0, e_err});
        end
        if (v.gap != 16'd0 && v.stall == 0 && !v.drop_en) begin
            for (int i = 1; i < start_cyc.size(); i++) begin
                if ((i % (1 << v.avg)) != 0)
                    chk({tag, "_start_spacing"}, start_cyc[i] - start_cyc[i-1], v.lat + 2 + int'(v.gap));
            end
        end
    endtask

    initial begin
        int t;
        //        base   nch   avg   gap    stall lat   drop  dch    mid npre pre                                               st  res mask     d0       to
        vecs[0] = '{5'h10, 4'd1, 3'd0, 16'd0,  0,   3,    1'b0, 5'h00, 1'b0, 1, {12'h000, 12'h000, 12'h000, 12'h5A3},          1,  1, 16'h0000, 12'h5A3, 1'b0};
        vecs[1] = '{5'h03, 4'd1, 3'd2, 16'd10, 0,   3,    1'b0, 5'h00, 1'b0, 4, {12'd104, 12'd102, 12'd101, 12'd100},          4,  1, 16'h0000, 12'd101, 1'b0};
        vecs[2] = '{5'h1E, 4'd4, 3'd0, 16'd0,  20,  3,    1'b0, 5'h00, 1'b0, 0, {12'h000, 12'h000, 12'h000, 12'h000},          4,  4, 16'h0000, 12'h11E, 1'b0};
        vecs[3] = '{5'h05, 4'd3, 3'd1, 16'd2,  0,   2,    1'b1, 5'h06, 1'b0, 0, {12'h000, 12'h000, 12'h000, 12'h000},          5,  3, 16'h0002, 12'h105, 1'b1};
        vecs[4] = '{5'h07, 4'd0, 3'd0, 16'd0,  0,   3,    1'b0, 5'h00, 1'b0, 0, {12'h000, 12'h000, 12'h000, 12'h000},          0,  0, 16'h0000, 12'h000, 1'b0};
        vecs[5] = '{5'h1F, 4'd2, 3'd3, 16'd1,  3,   5,    1'b0, 5'h00, 1'b0, 0, {12'h000, 12'h000, 12'h000, 12'h000},          16, 2, 16'h0000, 12'h11F, 1'b0};
        vecs[6] = '{5'h0C, 4'd1, 3'd0, 16'd0,  0,   TO-1, 1'b0, 5'h00, 1'b0, 0, {12'h000, 12'h000, 12'h000, 12'h000},          1,  1, 16'h0000, 12'h10C, 1'b0};
        vecs[7] = '{5'h08, 4'd2, 3'd1, 16'd0,  0,   3,    1'b0, 5'h00, 1'b1, 0, {12'h000, 12'h000, 12'h000, 12'h000},          4,  2, 16'h0000, 12'h108, 1'b0};

        repeat (3) @(negedge clk125);
        chk("reset_outputs", outs(), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk125);
        chk("idle_outputs", outs(), 32'd0);

        for (int i = 0; i < 8; i++) run_scan(vecs[i], $sformatf("v%0d", i));

        // Reset while a conversion is outstanding
        n_done_pulses = 0;
        stall_cyc     = 0;
        drop_en       = 1'b0;
        lat           = 50;
        ch_base       = 5'h02;
        n_ch          = 4'd2;
        avg_log2      = 3'd0;
        sample_gap    = 16'd0;
        @(negedge clk125);
        scan_start = 1'b1;
        @(negedge clk125);
        scan_start = 1'b0;
        t = 0;
        while (!xadc_start && t < 100) begin
            @(negedge clk125);
            t++;
        end
        chk("rst_seq_start_seen", {31'd0, t < 100}, 32'd1);
        repeat (5) @(negedge clk125);
        chk("rst_seq_busy_before", {31'd0, scan_busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_outputs", outs(), 32'd0);
        repeat (3) @(negedge clk125);
        chk("rst_no_scan_done", n_done_pulses, 32'd0);
        rst_n = 1'b1;
        run_scan(vecs[0], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xadc_scan_ctrl.md
Name: xadc_scan_ctrl

Overview:
- Upstream sequencer for the XADC single-channel reader. It drives that block's start/ch_sel inputs and consumes its done/result outputs.
- Walks a contiguous list of 5-bit channel codes and takes 2^k conversions per channel. It averages each channel's samples and emits one result per channel on a valid/ready stream to the readout/UDP packet builder.
- Provides a conversion watchdog so a stalled XADC transaction cannot hang a scan.

Parameters:
- TIMEOUT_CYC, 4096: clk125 cycles to wait for xadc_done after a start pulse before flagging a timeout.
- MAX_LOG2, 7: maximum supported log2 sample count. The accumulator is 12+MAX_LOG2 bits wide.

Ports:
- clk125  in  1  system clock, 125 MHz.
- rst_n  in  1  asynchronous active-low reset.
- scan_start  in  1  one-cycle request; latches the configuration and begins a scan.
- ch_base  in  5  first channel code of the scan.
- n_ch  in  4  number of channels to scan, 0..15.
- avg_log2  in  3  samples per channel = 2^avg_log2. Values above MAX_LOG2 are clamped to MAX_LOG2.
- sample_gap  in  16  idle cycles between consecutive conversions.
- xadc_start  out  1  start pulse to the reader.
- xadc_ch_sel  out  5  channel code to the reader.
- xadc_done  in  1  one-cycle completion pulse from the reader.
- xadc_result  in  12  reader result; valid in the cycle xadc_done is high.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_ch  out  5  channel code of the result.
- res_data  out  12  averaged result.
- res_err  out  1  result is invalid because of a timeout.
- scan_busy  out  1  high from the first cycle after scan_start is accepted until scan_done.
- scan_done  out  1  one-cycle pulse at the end of a scan.
- err_timeout  out  1  sticky error flag; cleared on the next accepted scan_start.

Behaviour:
- Clock and reset:
  - Single clock clk125.
  - rst_n is asynchronous and active-low; it is asserted asynchronously and released synchronously by the top level.
  - Reset drives all outputs to 0 (xadc_ch_sel=0, res_*=0) and puts the FSM in IDLE. Reset mid-scan aborts the scan with no scan_done pulse.
- All outputs are registered.
- Reader handshake, fixed by the reader's design:
  - xadc_start is exactly one cycle wide. xadc_ch_sel is valid in that cycle and held stable until the matching xadc_done or timeout.
  - xadc_start is never asserted while a transaction is outstanding. The reader requires start low before it will pulse done.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP, EMIT, FINISH.
  - IDLE: on scan_start, latch ch_base, n_ch, avg_log2 (clamped) and sample_gap. Clear err_timeout, the channel index and the accumulator. Go to FINISH if n_ch=0, otherwise to ISSUE. scan_start is ignored in every other state.
  - ISSUE: xadc_start=1 and xadc_ch_sel = (ch_base+idx) mod 32, so codes wrap 5'h1F→5'h00. Clear the watchdog. Go to WAIT_DONE.
  - WAIT_DONE, on xadc_done: acc += xadc_result and smp++. If smp = 2^k, go to EMIT; otherwise go to GAP, or directly to ISSUE if sample_gap=0.
  - WAIT_DONE, on watchdog = TIMEOUT_CYC-1 without done: set err_timeout, mark the channel errored, go to EMIT. Any remaining samples for that channel are abandoned.
  - WAIT_DONE, simultaneous done and timeout expiry in the same cycle: done wins and no error is raised.
  - GAP: count sample_gap cycles, then go to ISSUE.
  - EMIT:
    - Outputs: res_valid=1, res_ch = channel code, res_data = acc >> k (truncating; no rounding), res_err = error mark. On an errored channel res_data=12'hFFF and res_err=1.
    - Outputs hold stable while res_ready=0. The scan stalls under backpressure.
    - On res_valid & res_ready: clear acc, smp and the error mark, then idx++. Go to FINISH if idx+1 = n_ch, otherwise to ISSUE.
    - res_valid deasserts the cycle after acceptance.
  - FINISH: scan_done=1 for one cycle, scan_busy drops, go to IDLE.
- Latency:
  - scan_start → first xadc_start: 2 cycles.
  - xadc_done of the last sample → res_valid: 1 cycle.
- Accumulator: (12+MAX_LOG2) bits unsigned; it cannot overflow.

Optional Feature:
- Macro: XADC_SCAN_MINMAX_EN.
- Defined:
  - Adds outputs res_min[11:0] and res_max[11:0], the smallest and largest raw sample for the channel, valid with res_valid.
  - Both are reset to 12'hFFF/12'h000 at the start of each channel.
  - On an errored channel they report the values seen before the timeout; if no samples were taken they stay at 12'hFFF/12'h000.
- Not defined: the ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Single-sample scan: ch_base=5'h10, n_ch=1, avg_log2=0, gap=0; reader model returns 12'h5A3 → one xadc_start with ch_sel=5'h10; res_data=12'h5A3, res_ch=5'h10, res_err=0; then scan_done; err_timeout=0.
- Averaging and gap: n_ch=1, avg_log2=2, gap=10; returns 100,101,102,104 → exactly 4 starts spaced ≥10 idle cycles apart; res_data=101 (407>>2).
- Wrap-around and backpressure: ch_base=5'h1E, n_ch=4, res_ready held low 20 cycles per result → res_ch sequence 1E,1F,00,01; outputs stable while stalled; no xadc_start issued while EMIT is stalled.
- Timeout: the model never pulses done for channel 2 of 3 → after TIMEOUT_CYC cycles, res_err=1 and res_data=FFF for that channel; err_timeout stays set; remaining channels complete normally; the next scan_start clears err_timeout.
- Edge cases:
  - n_ch=0 → scan_done within 2 cycles and no xadc_start.
  - scan_start pulsed mid-scan → ignored.
  - Done coincident with the last watchdog cycle → no error.
- Reset mid-scan: rst_n low during WAIT_DONE → all outputs 0 immediately (asynchronously) and no scan_done; after release, a fresh scan completes normally.
